// File: rtl/mult_unit_pkg.sv
// rtl/mult_unit_pkg.sv - shared widths, decode keys and state encoding for the RV32M multiplier
package mult_unit_pkg;

  localparam int WORD_W   = 32;
  localparam int CNT_W    = 5;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;

  // R-type funct7 decode key used by the control unit
  typedef enum logic [FUNCT7_W-1:0] {
    MULT = 7'h01
  } funct7_r_t;

  // funct3 encodings of the multiply subset
  typedef enum logic [FUNCT3_W-1:0] {
    MUL    = 3'h0,
    MULH   = 3'h1,
    MULHSU = 3'h2,
    MULHU  = 3'h3
  } funct3_m_t;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_CALC,
    MUL_FIX,
    MUL_DONE
  } mult_state_t;

endpackage

// File: rtl/mult_if.sv
// rtl/mult_if.sv - request/response bundle between the execute stage and the multiplier
//   master (execute stage): drives start, kill, funct3, a, b; observes busy, done, result
//   slave  (mult_unit)    : observes the request, drives busy, done, result
interface mult_if;
  import mult_unit_pkg::*;

  logic                start;
  logic                kill;
  logic [FUNCT3_W-1:0] funct3;
  logic [WORD_W-1:0]   a;
  logic [WORD_W-1:0]   b;
  logic                busy;
  logic                done;
  logic [WORD_W-1:0]   result;

  modport master (
    output start, kill, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mult_if.slave (start, kill, funct3, a, b in; busy, done, result out)
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  mult_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_W - 1);

  mult_state_t           r_state;
  logic [FUNCT3_W-1:0]   r_funct3;
  logic                  r_neg;
  logic [WORD_W-1:0]     r_mcand;
  logic [WORD_W-1:0]     r_mplier;
  logic [2*WORD_W-1:0]   r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [WORD_W-1:0]     r_result;

  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [WORD_W-1:0]     w_mag_a;
  logic [WORD_W-1:0]     w_mag_b;
  logic [WORD_W:0]       w_sum;
  logic [2*WORD_W-1:0]   w_prod;
  logic [WORD_W-1:0]     w_fix_result;
  logic                  w_can_accept;

  function automatic logic [2*WORD_W-1:0] neg2(input logic [2*WORD_W-1:0] x);
    return ~x + (2*WORD_W)'(1);
  endfunction

  // Operand signedness: MULHU treats both unsigned, MULHSU only rs1 signed
  assign w_a_signed = (bus.funct3 != FUNCT3_W'(MULHU));
  assign w_b_signed = (bus.funct3 == FUNCT3_W'(MUL)) || (bus.funct3 == FUNCT3_W'(MULH));
  assign w_a_neg    = w_a_signed & bus.a[WORD_W-1];
  assign w_b_neg    = w_b_signed & bus.b[WORD_W-1];
  // -2^31 negates to itself, which read as unsigned is the correct magnitude 2^31
  assign w_mag_a    = w_a_neg ? (~bus.a + WORD_W'(1)) : bus.a;
  assign w_mag_b    = w_b_neg ? (~bus.b + WORD_W'(1)) : bus.b;

  // Upper-half add keeps its carry so the right shift can pull it into bit 63
  assign w_sum = {1'b0, r_acc[2*WORD_W-1:WORD_W]} +
                 {1'b0, (r_mplier[0] ? r_mcand : '0)};

  assign w_prod = r_neg ? neg2(r_acc) : r_acc;

  always_comb begin
    w_fix_result = '0;
    if (r_funct3[FUNCT3_W-1]) begin
      w_fix_result = '0;
    end else if (r_funct3 == FUNCT3_W'(MUL)) begin
      w_fix_result = w_prod[WORD_W-1:0];
    end else begin
      w_fix_result = w_prod[2*WORD_W-1:WORD_W];
    end
  end

  assign w_can_accept = (r_state == MUL_IDLE) || (r_state == MUL_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MUL_IDLE;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.kill) begin
      // Flush wins over everything, including a same-edge start or a pending FIX
      r_state <= MUL_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE, MUL_DONE: begin
          r_done <= 1'b0;
          if (w_can_accept && bus.start) begin
            r_funct3 <= bus.funct3;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= MUL_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= MUL_IDLE;
          end
        end
        MUL_CALC: begin
          r_acc    <= {w_sum, r_acc[WORD_W-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= MUL_FIX;
          end
        end
        MUL_FIX: begin
          r_result <= w_fix_result;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= MUL_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= MUL_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - directed self-checking bench for mult_unit
module tb_mult_unit;
  import mult_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_if bus();

  mult_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issues one request and waits for done; lat counts negedges after the accept edge
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    bus.funct3 = 3'($urandom_range(0, 7));
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_mul_timing();
    logic exp_busy, exp_done;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'h0; bus.a = 32'd7; bus.b = 32'd6;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.start = 1'b0; bus.a = 32'hFFFF_0000; bus.b = 32'h1234_5678; end
      exp_busy = (k - 1) <= 32;
      exp_done = (k - 1) == 33;
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL mul_busy_edge%0d: got %b expected %b", k - 1, bus.busy, exp_busy); end
      n_checks++; if (bus.done !== exp_done) begin n_fail++; $display("FAIL mul_done_edge%0d: got %b expected %b", k - 1, bus.done, exp_done); end
      if (k == 34) begin
        n_checks++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL mul_7x6: got %h expected 0000002a", bus.result); end
      end
    end
  endtask

  task automatic test_signed_ops();
    logic [31:0] res;
    int lat;
    run_op(3'h1, 32'h8000_0000, 32'h8000_0000, res, lat);
    n_checks++; if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_min_min: got %h expected 40000000", res); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mulh_latency: got %0d expected 34", lat); end
    run_op(3'h0, 32'h8000_0000, 32'h8000_0000, res, lat);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL mul_min_min: got %h expected 00000000", res); end
    run_op(3'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_m1: got %h expected ffffffff", res); end
    run_op(3'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max: got %h expected fffffffe", res); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mulhu_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'h0; bus.a = 32'd3; bus.b = 32'hFFFF_FFFB;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    n_checks++; if (bus.result !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL b2b_mul_3xm5: got %h expected fffffff1", bus.result); end
    bus.start = 1'b1; bus.funct3 = 3'h1; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle_done: got %b expected 0", bus.done); end
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    n_checks++; if (bus.result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_mulh_m3x5: got %h expected ffffffff", bus.result); end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int lat, n_done, n_busy;
    run_op(3'h0, 32'd7, 32'd6, res, lat);
    n_checks++; if (res !== 32'h2A) begin n_fail++; $display("FAIL kill_setup: got %h expected 0000002a", res); end
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 kills at CALC iteration 10 (edge 10), pass 1 kills in FIX (edge 33)
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'h0; bus.a = 32'd9; bus.b = 32'd9;
      for (int k = 1; k <= ((pass == 0) ? 10 : 33); k++) begin
        @(negedge clk);
        if (k == 1) bus.start = 1'b0;
      end
      if (pass == 1) begin
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL kill_fix_busy: got %b expected 1", bus.busy); end
      end
      bus.kill = 1'b1; bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd3;
      @(negedge clk);
      bus.kill = 1'b0; bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill%0d_busy: got %b expected 0", pass, bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL kill%0d_done: got %b expected 0", pass, bus.done); end
      n_checks++; if (bus.result !== 32'h2A) begin n_fail++; $display("FAIL kill%0d_result: got %h expected 0000002a", pass, bus.result); end
      n_done = 0; n_busy = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done === 1'b1) n_done++;
        if (bus.busy === 1'b1) n_busy++;
      end
      n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL kill%0d_no_done: got %0d pulses expected 0", pass, n_done); end
      n_checks++; if (n_busy !== 0) begin n_fail++; $display("FAIL kill%0d_start_ignored: got %0d busy cycles expected 0", pass, n_busy); end
    end
  endtask

  task automatic test_rst_async();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'h0; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL arst_result: got %h expected 00000000", bus.result); end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'h0, 32'h1234_5678, 32'h10, res, lat);
    n_checks++; if (res !== 32'h2345_6780) begin n_fail++; $display("FAIL mul_after_rst: got %h expected 23456780", res); end
    run_op(3'h4, 32'hDEAD_BEEF, 32'h0000_1234, res, lat);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL div_encoding: got %h expected 00000000", res); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_signed_ops();
    test_back_to_back();
    test_kill();
    test_rst_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multi-cycle multiplier for the RV32M multiply subset: MUL, MULH, MULHSU and MULHU.
- Sits in the execute stage beside the ALU. It consumes R-type instructions with funct7 = MULT (7'h01) and funct3 in 0..3.
- The execute stage stalls the pipeline on busy and writes back result when done pulses.
- Radix-2 shift-add core on operand magnitudes, followed by a single sign-fix cycle.

Parameters:
- WORD_W, 32, operand and result width (taken from the shared package; the block is verified only at 32).
- CNT_W, 5, iteration counter width, equal to log2(WORD_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only when the unit can accept.
- kill  input  1  pipeline flush; aborts any operation in flight.
- funct3  input  3  operation select: 0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU.
- a  input  WORD_W  rs1 operand.
- b  input  WORD_W  rs2 operand.
- busy  output  1  high while in CALC or FIX.
- done  output  1  single-cycle pulse; result is valid in that cycle.
- result  output  WORD_W  registered result, held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy, done, result, counter and all datapath registers = 0.
- States:
  - IDLE: waiting for a request.
  - CALC: 32 shift-add iterations.
  - FIX: apply sign and select the output half.
  - DONE: done = 1 for exactly one cycle.
- Acceptance: start = 1 and kill = 0 at an edge while in IDLE or DONE. At that edge:
  - latch funct3;
  - latch neg_res = sign(a)&a_signed XOR sign(b)&b_signed;
  - latch magnitudes |a| and |b|. Signedness per operation: MUL and MULH treat both operands as signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned. A magnitude of -2^31 is 2^31 and fits in 32 unsigned bits;
  - clear the 64-bit accumulator and set counter = 0;
  - go to CALC.
- CALC, each edge: if multiplier bit 0 = 1, add the multiplicand to the upper half of the accumulator. Shift the {carry, accumulator} right by 1, and shift the multiplier right by 1. After the 32nd iteration (counter wraps 31 -> 0), go to FIX.
- FIX edge: prod = neg_res ? (~acc + 1) : acc, using 64-bit two's complement. result <= (funct3 == 0) ? prod[31:0] : prod[63:32]. Go to DONE; done becomes 1.
- DONE: done = 1 for this cycle only.
  - start accepted here: back-to-back, go to CALC.
  - otherwise: go to IDLE.
- Latency: with the accept edge as edge 0, done is high in the cycle following edge 33. The next start can be accepted at edge 34 at the earliest.
- start while busy: ignored. No queueing, and no effect on the operation in flight.
- funct3[2] = 1 (divide encodings, not supported): the request is accepted, sequenced normally, and returns result = 0.
- kill: synchronous abort with priority over everything except rst.
  - From any state it forces IDLE at the next edge.
  - The cycle after a kill edge always has done = 0, including when kill is asserted in FIX.
  - result keeps its previous value.
  - kill and start at the same edge: start is ignored.
- rst asserted mid-operation: immediate return to reset values, with no done pulse.
- Operands a, b and funct3 need to be valid only at the accept edge; later changes have no effect.
- result changes only at a FIX edge or at reset.

Decomposition:
- Shared package additions: enum mult_state_t {MUL_IDLE, MUL_CALC, MUL_FIX, MUL_DONE}.
- Shared package additions: typedef enum funct3_m_t, with MUL = 3'h0, MULH = 3'h1, MULHSU = 3'h2, MULHU = 3'h3, reusing FUNCT3_W and WORD_W.
- The existing funct7_r_t value MULT remains the decode key in the control unit.
- Sub-module: none required. The 64-bit two's-complement negation may be a small local function.

Test Plan:
- MUL, a = 7, b = 6 -> done rises in the cycle after edge 33 and stays high exactly one cycle; result = 42; busy high in the cycles after edges 0..32.
- MULH, a = 0x80000000, b = 0x80000000 -> result = 0x40000000. MUL with the same operands -> result = 0x00000000.
- MULHSU, a = 0xFFFFFFFF (-1), b = 0xFFFFFFFF -> result = 0xFFFFFFFF. MULHU with the same operands -> result = 0xFFFFFFFE.
- Back-to-back: MUL 3 x -5 with start held through the DONE cycle, next op MULH -3 x 5 -> first result 0xFFFFFFF1, second result 0xFFFFFFFF, no idle cycle between the two operations.
- kill asserted at CALC iteration 10 and separately in FIX -> no done pulse, result unchanged from the previous value (0x2A), and a start asserted at the kill edge is ignored.
- rst pulsed asynchronously mid-CALC -> busy, done and result go to 0 immediately; then MUL with a = 0x12345678, b = 0x10 -> result = 0x23456780. funct3 = 4 with any operands -> result = 0.
